// File: rtl/noc_pkg.sv
// noc_pkg
// Shared definitions for the NoC flit link: flit field widths, the flit
// record carried between router ports and local adapters, the default
// credit/buffer depth, and small helpers used by the flit-side blocks.
package noc_pkg;

    localparam int FLIT_WIDTH   = 32;
    localparam int TDEST_WIDTH  = 4;
    localparam int TID_WIDTH    = 2;
    localparam int DEST_WIDTH   = TDEST_WIDTH + TID_WIDTH;
    localparam int BUFFER_DEPTH = 4;

    // One flit as stored in a credit buffer. dest is {tid, tdest}.
    typedef struct packed {
        logic [FLIT_WIDTH-1:0] data;
        logic [DEST_WIDTH-1:0] dest;
        logic                  is_tail;
    } flit_t;

    // Output register of an egress adapter: either holding a beat for the
    // sink or free to accept the next completed beat.
    typedef enum logic {
        OUT_FREE  = 1'b0,
        OUT_VALID = 1'b1
    } out_state_e;

    // Width of a counter that indexes n slots; never less than one bit so a
    // single-slot collector still has a legal counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/noc_credit_fifo.sv
// noc_credit_fifo
// Synchronous FIFO holding flits between the link and a consumer. Its depth
// equals the number of credits the transmitter starts with, so under a
// correct credit protocol it never overflows. A push while full is refused
// unless a pop happens on the same edge, which frees the slot in time.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset (empties the FIFO)
//   push       write push_data this edge (ignored when full without a pop)
//   push_data  flit to store
//   pop        remove the head this edge (ignored when empty)
//   pop_data   current head flit (valid only when empty=0)
//   full       all DEPTH slots occupied
//   empty      no flit stored
module noc_credit_fifo #(
    parameter type T     = noc_pkg::flit_t,
    parameter int  DEPTH = noc_pkg::BUFFER_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     pop_data,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    T            mem [DEPTH];
    logic        wr_en;
    logic        rd_en;

    always_comb begin
        empty    = (wr_ptr == rd_ptr);
        full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        rd_en    = pop && !empty;
        wr_en    = push && (!full || rd_en);
        pop_data = mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/noc_flit_to_axis_rx.sv
// noc_flit_to_axis_rx
// Egress adapter on a router's local output port. Flits arriving on the
// credit-controlled link are buffered, gathered SERIALIZATION_FACTOR at a time
// (or up to a tail flit) into one AXI-Stream beat, and presented to the
// attached sink. One credit pulse is returned for each flit leaving the buffer.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   data_in           flit payload
//   dest_in           flit destination {tid, tdest}
//   is_tail_in        last flit of the packet
//   send_in           flit valid this cycle
//   credit_out        one-cycle pulse per freed buffer slot
//   axis_out_*        AXI-Stream master: tvalid/tready/tdata/tlast/tdest/tid
//   overflow_err      sticky: a flit arrived while the buffer was full
module noc_flit_to_axis_rx #(
    parameter int FLIT_WIDTH           = noc_pkg::FLIT_WIDTH,
    parameter int SERIALIZATION_FACTOR = 1,
    parameter int TDEST_WIDTH          = noc_pkg::TDEST_WIDTH,
    parameter int TID_WIDTH            = noc_pkg::TID_WIDTH,
    parameter int DEST_WIDTH           = TDEST_WIDTH + TID_WIDTH,
    parameter int BUFFER_DEPTH         = noc_pkg::BUFFER_DEPTH,
    parameter int TDATA_WIDTH          = FLIT_WIDTH * SERIALIZATION_FACTOR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FLIT_WIDTH-1:0]  data_in,
    input  logic [DEST_WIDTH-1:0]  dest_in,
    input  logic                   is_tail_in,
    input  logic                   send_in,
    output logic                   credit_out,
    output logic                   axis_out_tvalid,
    input  logic                   axis_out_tready,
    output logic [TDATA_WIDTH-1:0] axis_out_tdata,
    output logic                   axis_out_tlast,
    output logic [TDEST_WIDTH-1:0] axis_out_tdest,
    output logic [TID_WIDTH-1:0]   axis_out_tid,
    output logic                   overflow_err
);

    import noc_pkg::*;

    localparam int SF    = SERIALIZATION_FACTOR;
    localparam int CNT_W = cnt_width(SF);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SF - 1);

    typedef struct packed {
        logic [FLIT_WIDTH-1:0] data;
        logic [DEST_WIDTH-1:0] dest;
        logic                  is_tail;
    } rx_flit_t;

    rx_flit_t               in_flit;
    rx_flit_t               head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;
    logic                   completes;
    logic                   load;
    logic                   out_free;
    logic                   overflow;
    logic [CNT_W-1:0]       count;
    logic [FLIT_WIDTH-1:0]  slots [SF];
    logic [DEST_WIDTH-1:0]  beat_dest;
    logic [DEST_WIDTH-1:0]  first_dest;
    logic [TDATA_WIDTH-1:0] beat_data;
    out_state_e             out_state;

    assign in_flit = '{data: data_in, dest: dest_in, is_tail: is_tail_in};

    noc_credit_fifo #(
        .T     (rx_flit_t),
        .DEPTH (BUFFER_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (send_in),
        .push_data (in_flit),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A flit that would complete a beat may only leave the FIFO when the
    // output register can take the beat on this edge (free, or draining).
    // The beat is assembled with the head flit dropped into its slot; slots
    // above it are still zero from the last clear, which zero-fills early tails.
    always_comb begin
        completes  = (count == LAST_SLOT) || head.is_tail;
        out_free   = (out_state == OUT_FREE) || axis_out_tready;
        pop        = !fifo_empty && (!completes || out_free);
        load       = pop && completes;
        overflow   = send_in && fifo_full && !pop;
        first_dest = (count == '0) ? head.dest : beat_dest;
        beat_data  = '0;
        for (int i = 0; i < SF; i++) begin
            beat_data[i*FLIT_WIDTH +: FLIT_WIDTH] =
                (count == CNT_W'(i)) ? head.data : slots[i];
        end
    end

    // Collector: partial beats accumulate here; a completed beat clears every
    // slot so the next beat starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            beat_dest <= '0;
            for (int i = 0; i < SF; i++) slots[i] <= '0;
        end else if (pop) begin
            if (completes) begin
                count <= '0;
                for (int i = 0; i < SF; i++) slots[i] <= '0;
            end else begin
                count <= count + 1'b1;
                if (count == '0) beat_dest <= head.dest;
                for (int i = 0; i < SF; i++) begin
                    if (count == CNT_W'(i)) slots[i] <= head.data;
                end
            end
        end
    end

    // Output register: a new beat may replace one being accepted on the same
    // edge, giving back-to-back beats without a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_state      <= OUT_FREE;
            axis_out_tdata <= '0;
            axis_out_tlast <= 1'b0;
            axis_out_tdest <= '0;
            axis_out_tid   <= '0;
        end else begin
            if (load) begin
                axis_out_tdata <= beat_data;
                axis_out_tlast <= head.is_tail;
                axis_out_tdest <= first_dest[TDEST_WIDTH-1:0];
                axis_out_tid   <= first_dest[DEST_WIDTH-1:TDEST_WIDTH];
            end
            case (out_state)
                OUT_FREE:  if (load) out_state <= OUT_VALID;
                OUT_VALID: if (!load && axis_out_tready) out_state <= OUT_FREE;
                default:   out_state <= OUT_FREE;
            endcase
        end
    end

    assign axis_out_tvalid = (out_state == OUT_VALID);

    // A credit goes back one cycle after each pop; a refused flit earns none
    // and latches the protocol-violation flag until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_out   <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            credit_out <= pop;
            if (overflow) overflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_noc_flit_to_axis_rx.sv
// tb_noc_flit_to_axis_rx
// Drives two adapters side by side: instance a with one flit per beat and
// instance b with two flits per beat. Expected beats come from a packet-level
// model that groups flits into beats; observed beats and credit pulses are
// recorded at the falling edge.
module tb_noc_flit_to_axis_rx;

    localparam int DEPTH = 4;

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic [3:0]  tdest;
        logic [1:0]  tid;
        int          cyc;
    } beat_t;

    typedef struct {
        logic [31:0] d;
        logic [5:0]  dest;
        logic        tail;
    } tflit_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] a_data, a_tdata;
    logic [5:0]  a_dest;
    logic        a_tail, a_send, a_credit, a_tvalid, a_tready, a_tlast, a_ovf;
    logic [3:0]  a_tdest;
    logic [1:0]  a_tid;

    logic [31:0] b_data;
    logic [63:0] b_tdata;
    logic [5:0]  b_dest;
    logic        b_tail, b_send, b_credit, b_tvalid, b_tready, b_tlast, b_ovf;
    logic [3:0]  b_tdest;
    logic [1:0]  b_tid;

    noc_flit_to_axis_rx #(.SERIALIZATION_FACTOR(1), .TDATA_WIDTH(32)) dut_a (
        .clk(clk), .rst(rst), .data_in(a_data), .dest_in(a_dest),
        .is_tail_in(a_tail), .send_in(a_send), .credit_out(a_credit),
        .axis_out_tvalid(a_tvalid), .axis_out_tready(a_tready),
        .axis_out_tdata(a_tdata), .axis_out_tlast(a_tlast),
        .axis_out_tdest(a_tdest), .axis_out_tid(a_tid), .overflow_err(a_ovf)
    );

    noc_flit_to_axis_rx #(.SERIALIZATION_FACTOR(2), .TDATA_WIDTH(64)) dut_b (
        .clk(clk), .rst(rst), .data_in(b_data), .dest_in(b_dest),
        .is_tail_in(b_tail), .send_in(b_send), .credit_out(b_credit),
        .axis_out_tvalid(b_tvalid), .axis_out_tready(b_tready),
        .axis_out_tdata(b_tdata), .axis_out_tlast(b_tlast),
        .axis_out_tdest(b_tdest), .axis_out_tid(b_tid), .overflow_err(b_ovf)
    );

    int    tests = 0;
    int    fails = 0;
    int    cycle = 0;
    int    cred_a = 0;
    int    cred_b = 0;
    beat_t obs_a[$];
    beat_t obs_b[$];
    beat_t exp_a[$];
    beat_t exp_b[$];

    logic [63:0] acc_data [2];
    logic [5:0]  acc_dest [2];
    int          acc_n    [2];

    always @(posedge clk) cycle <= cycle + 1;

    // Record credits and accepted beats; inputs only change just after the
    // rising edge, so values seen here are what the next edge acts on.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_credit) cred_a <= cred_a + 1;
            if (b_credit) cred_b <= cred_b + 1;
            if (a_tvalid && a_tready)
                obs_a.push_back('{data: {32'h0, a_tdata}, last: a_tlast,
                                  tdest: a_tdest, tid: a_tid, cyc: cycle});
            if (b_tvalid && b_tready)
                obs_b.push_back('{data: b_tdata, last: b_tlast,
                                  tdest: b_tdest, tid: b_tid, cyc: cycle});
        end
    end

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            acc_data[k] = '0;
            acc_dest[k] = '0;
            acc_n[k]    = 0;
        end
    endtask

    // Packet-level grouping: a beat is the next SF flits, cut short by a tail.
    task automatic model_flit(input int inst, input logic [31:0] d,
                              input logic [5:0] dest, input logic tail);
        int    sf;
        beat_t b;
        sf = (inst == 0) ? 1 : 2;
        if (acc_n[inst] == 0) acc_dest[inst] = dest;
        acc_data[inst][acc_n[inst]*32 +: 32] = d;
        acc_n[inst]++;
        if (acc_n[inst] == sf || tail) begin
            b = '{data: acc_data[inst], last: tail, tdest: acc_dest[inst][3:0],
                  tid: acc_dest[inst][5:4], cyc: 0};
            if (inst == 0) exp_a.push_back(b);
            else           exp_b.push_back(b);
            acc_data[inst] = '0;
            acc_n[inst]    = 0;
        end
    endtask

    // One clock of stimulus on one instance; returns just after the edge.
    task automatic applyStimulus(input int inst, input logic send, input logic [31:0] d,
                                 input logic [5:0] dest, input logic tail,
                                 input logic tready);
        if (inst == 0) begin
            a_send = send; a_data = d; a_dest = dest; a_tail = tail; a_tready = tready;
        end else begin
            b_send = send; b_data = d; b_dest = dest; b_tail = tail; b_tready = tready;
        end
        @(posedge clk);
        #1;
        a_send = 1'b0;
        b_send = 1'b0;
    endtask

    task automatic wait_beats(input int inst, input int n, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            if (((inst == 0) ? obs_a.size() : obs_b.size()) >= n) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a_send = 1'b1; b_send = 1'b1;
            a_data = $urandom; b_data = $urandom;
            a_dest = 6'h3F; b_dest = 6'h3F; a_tail = 1'b1; b_tail = 1'b1;
            @(posedge clk);
            #1;
        end
        tests++;
        if ({a_tvalid, a_tdata, a_tlast, a_tdest, a_tid, a_credit, a_ovf} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_a: outputs %h, expected 0",
                     {a_tvalid, a_tdata, a_tlast, a_tdest, a_tid, a_credit, a_ovf});
        end
        tests++;
        if ({b_tvalid, b_tdata, b_tlast, b_tdest, b_tid, b_credit, b_ovf} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_b: outputs %h, expected 0",
                     {b_tvalid, b_tdata, b_tlast, b_tdest, b_tid, b_credit, b_ovf});
        end
        a_send = 1'b0; b_send = 1'b0;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (cred_a + cred_b != 0 || obs_a.size() + obs_b.size() != 0 || a_tvalid || b_tvalid) begin
            fails++;
            $display("[TB] FAIL reset_ignored: credits %0d beats %0d, expected 0 and 0",
                     cred_a + cred_b, obs_a.size() + obs_b.size());
        end
    endtask

    task automatic test_single();
        int c0;
        c0 = cred_a;
        obs_a.delete(); exp_a.delete();
        model_flit(0, 32'hA5A5_0001, 6'b10_0011, 1'b1);
        applyStimulus(0, 1'b1, 32'hA5A5_0001, 6'b10_0011, 1'b1, 1'b1);
        tests++;
        if (a_tvalid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL single_early: tvalid %b after 1 edge, expected 0", a_tvalid);
        end
        @(posedge clk);
        #1;
        tests++;
        if (a_tvalid !== 1'b1 || a_credit !== 1'b1 || a_tdata !== 32'hA5A5_0001 ||
            a_tdest !== 4'd3 || a_tid !== 2'd2 || a_tlast !== 1'b1) begin
            fails++;
            $display("[TB] FAIL single_beat: valid=%b credit=%b data=%h dest=%0d id=%0d last=%b, expected 1 1 a5a50001 3 2 1",
                     a_tvalid, a_credit, a_tdata, a_tdest, a_tid, a_tlast);
        end
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (obs_a.size() != 1 || cred_a - c0 != 1) begin
            fails++;
            $display("[TB] FAIL single_count: beats %0d credits %0d, expected 1 and 1",
                     obs_a.size(), cred_a - c0);
        end
    endtask

    task automatic test_sf2_packet();
        int          c0;
        bit          ok;
        logic [31:0] d [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        logic [5:0]  ds[4] = '{6'h15, 6'h2A, 6'h07, 6'h38};
        c0 = cred_b;
        obs_b.delete(); exp_b.delete();
        for (int k = 0; k < 4; k++) begin
            model_flit(1, d[k], ds[k], k == 3);
            applyStimulus(1, 1'b1, d[k], ds[k], k == 3, 1'b1);
        end
        wait_beats(1, 2, ok);
        tests++;
        if (!ok || obs_b.size() != exp_b.size() || cred_b - c0 != 4) begin
            fails++;
            $display("[TB] FAIL sf2_count: beats %0d credits %0d, expected %0d and 4",
                     obs_b.size(), cred_b - c0, exp_b.size());
        end
        for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
            tests++;
            if (obs_b[i].data !== exp_b[i].data || obs_b[i].last !== exp_b[i].last ||
                obs_b[i].tdest !== exp_b[i].tdest || obs_b[i].tid !== exp_b[i].tid) begin
                fails++;
                $display("[TB] FAIL sf2_beat%0d: got %h/%b/%0d/%0d, expected %h/%b/%0d/%0d", i,
                         obs_b[i].data, obs_b[i].last, obs_b[i].tdest, obs_b[i].tid,
                         exp_b[i].data, exp_b[i].last, exp_b[i].tdest, exp_b[i].tid);
            end
        end
    endtask

    task automatic test_early_tail();
        bit          ok;
        logic [31:0] d [3] = '{32'h1111, 32'h2222, 32'h3333};
        logic [5:0]  ds[3] = '{6'h01, 6'h12, 6'h2E};
        obs_b.delete(); exp_b.delete();
        for (int k = 0; k < 3; k++) begin
            model_flit(1, d[k], ds[k], k == 2);
            applyStimulus(1, 1'b1, d[k], ds[k], k == 2, 1'b1);
        end
        wait_beats(1, 2, ok);
        tests++;
        if (!ok || obs_b.size() != 2) begin
            fails++;
            $display("[TB] FAIL tail_count: beats %0d, expected 2", obs_b.size());
        end else begin
            tests++;
            if (obs_b[1].data !== exp_b[1].data || obs_b[1].last !== 1'b1 ||
                obs_b[1].tdest !== 4'hE || obs_b[1].tid !== 2'd2) begin
                fails++;
                $display("[TB] FAIL tail_beat: got %h/%b/%0d/%0d, expected %h/1/14/2",
                         obs_b[1].data, obs_b[1].last, obs_b[1].tdest, obs_b[1].tid,
                         exp_b[1].data);
            end
            tests++;
            if (obs_b[0].data !== exp_b[0].data || obs_b[0].last !== 1'b0 || obs_b[0].tdest !== 4'h1) begin
                fails++;
                $display("[TB] FAIL tail_first: got %h/%b/%0d, expected %h/0/1",
                         obs_b[0].data, obs_b[0].last, obs_b[0].tdest, exp_b[0].data);
            end
        end
    endtask

    task automatic test_backpressure();
        int          c0;
        bit          ok;
        bit          held;
        logic [31:0] d [4];
        c0 = cred_a;
        obs_a.delete(); exp_a.delete();
        for (int k = 0; k < 4; k++) begin
            d[k] = $urandom;
            model_flit(0, d[k], 6'(k + 8), 1'b1);
            applyStimulus(0, 1'b1, d[k], 6'(k + 8), 1'b1, 1'b0);
        end
        held = 1'b1;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(0, 1'b0, '0, '0, 1'b0, 1'b0);
            if (a_tvalid !== 1'b1 || a_tdata !== d[0] || a_tdest !== 4'd8) held = 1'b0;
        end
        tests++;
        if (held !== 1'b1 || cred_a - c0 != 1 || obs_a.size() != 0) begin
            fails++;
            $display("[TB] FAIL bp_hold: held=%b credits %0d beats %0d, expected 1, 1, 0",
                     held, cred_a - c0, obs_a.size());
        end
        applyStimulus(0, 1'b0, '0, '0, 1'b0, 1'b1);
        wait_beats(0, 4, ok);
        tests++;
        if (!ok || obs_a.size() != 4 || cred_a - c0 != 4) begin
            fails++;
            $display("[TB] FAIL bp_drain: beats %0d credits %0d, expected 4 and 4",
                     obs_a.size(), cred_a - c0);
        end
        for (int i = 0; i < 4 && i < obs_a.size(); i++) begin
            tests++;
            if (obs_a[i].data !== exp_a[i].data || obs_a[i].tdest !== exp_a[i].tdest ||
                (i > 0 && obs_a[i].cyc != obs_a[i-1].cyc + 1)) begin
                fails++;
                $display("[TB] FAIL bp_beat%0d: got %h dest %0d cyc %0d, expected %h dest %0d, no gap",
                         i, obs_a[i].data, obs_a[i].tdest, obs_a[i].cyc,
                         exp_a[i].data, exp_a[i].tdest);
            end
        end
    endtask

    task automatic test_overflow();
        int c0;
        bit ok;
        logic [31:0] d;
        c0 = cred_a;
        obs_a.delete(); exp_a.delete();
        for (int k = 0; k < 5; k++) begin
            d = $urandom;
            model_flit(0, d, 6'(k), 1'b1);
            applyStimulus(0, 1'b1, d, 6'(k), 1'b1, 1'b0);
        end
        tests++;
        if (a_ovf !== 1'b0) begin
            fails++;
            $display("[TB] FAIL ovf_legal: overflow_err %b with buffer just full, expected 0", a_ovf);
        end
        applyStimulus(0, 1'b1, 32'hDEAD_BEEF, 6'h3F, 1'b1, 1'b0);
        tests++;
        if (a_ovf !== 1'b1) begin
            fails++;
            $display("[TB] FAIL ovf_set: overflow_err %b, expected 1", a_ovf);
        end
        repeat (5) applyStimulus(0, 1'b0, '0, '0, 1'b0, 1'b0);
        tests++;
        if (cred_a - c0 != 1) begin
            fails++;
            $display("[TB] FAIL ovf_credit: credits %0d while stalled, expected 1", cred_a - c0);
        end
        applyStimulus(0, 1'b0, '0, '0, 1'b0, 1'b1);
        wait_beats(0, 5, ok);
        tests++;
        if (!ok || obs_a.size() != 5 || cred_a - c0 != 5 || a_ovf !== 1'b1) begin
            fails++;
            $display("[TB] FAIL ovf_drain: beats %0d credits %0d ovf %b, expected 5, 5, 1",
                     obs_a.size(), cred_a - c0, a_ovf);
        end
        for (int i = 0; i < 5 && i < obs_a.size(); i++) begin
            tests++;
            if (obs_a[i].data !== exp_a[i].data || obs_a[i].tdest !== exp_a[i].tdest) begin
                fails++;
                $display("[TB] FAIL ovf_beat%0d: got %h dest %0d, expected %h dest %0d",
                         i, obs_a[i].data, obs_a[i].tdest, exp_a[i].data, exp_a[i].tdest);
            end
        end
    endtask

    task automatic test_reset_midpacket();
        int c0;
        bit ok;
        for (int k = 0; k < 3; k++)
            applyStimulus(1, 1'b1, 32'hBAD0_0000 + k, 6'h3F, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, '0, '0, 1'b0, 1'b0);
        tests++;
        if (b_tvalid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL mid_setup: tvalid %b before reset, expected 1", b_tvalid);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({b_tvalid, b_tdata, b_tlast, b_tdest, b_tid, b_credit, b_ovf, a_ovf} !== '0) begin
            fails++;
            $display("[TB] FAIL mid_reset: outputs %h, expected 0",
                     {b_tvalid, b_tdata, b_tlast, b_tdest, b_tid, b_credit, b_ovf, a_ovf});
        end
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        obs_b.delete(); exp_b.delete();
        c0 = cred_b;
        model_flit(1, 32'h0C0F_FEE5, 6'h29, 1'b1);
        applyStimulus(1, 1'b1, 32'h0C0F_FEE5, 6'h29, 1'b1, 1'b1);
        wait_beats(1, 1, ok);
        tests++;
        if (!ok || obs_b.size() != 1 || cred_b - c0 != 1 || obs_b[0].data !== exp_b[0].data ||
            obs_b[0].last !== 1'b1 || obs_b[0].tdest !== 4'h9 || obs_b[0].tid !== 2'd2) begin
            fails++;
            $display("[TB] FAIL mid_fresh: beats %0d credits %0d data %h, expected 1, 1, %h",
                     obs_b.size(), cred_b - c0, (obs_b.size() > 0) ? obs_b[0].data : 64'h0,
                     exp_b[0].data);
        end
    endtask

    task automatic test_random();
        for (int inst = 0; inst < 2; inst++) begin
            tflit_t fq[$];
            int     c0, sent, idx, budget, left;
            bit     ok, go, tr;
            obs_a.delete(); exp_a.delete(); obs_b.delete(); exp_b.delete();
            c0 = (inst == 0) ? cred_a : cred_b;
            for (int p = 0; p < 12; p++) begin
                left = $urandom_range(1, 5);
                for (int k = 0; k < left; k++) begin
                    tflit_t f;
                    f.d = $urandom;
                    f.dest = 6'($urandom_range(0, 63));
                    f.tail = (k == left - 1);
                    fq.push_back(f);
                    model_flit(inst, f.d, f.dest, f.tail);
                end
            end
            sent = 0; idx = 0; budget = 0;
            while (idx < fq.size() && budget < 3000) begin
                tr = ($urandom_range(0, 3) != 0);
                go = (sent - (((inst == 0) ? cred_a : cred_b) - c0) < DEPTH) &&
                     ($urandom_range(0, 4) != 0);
                applyStimulus(inst, go, fq[idx].d, fq[idx].dest, fq[idx].tail, tr);
                if (go) begin idx++; sent++; end
                budget++;
            end
            applyStimulus(inst, 1'b0, '0, '0, 1'b0, 1'b1);
            wait_beats(inst, (inst == 0) ? exp_a.size() : exp_b.size(), ok);
            tests++;
            if (!ok || idx != fq.size() ||
                ((inst == 0) ? obs_a.size() != exp_a.size() : obs_b.size() != exp_b.size()) ||
                ((inst == 0) ? cred_a : cred_b) - c0 != fq.size() ||
                ((inst == 0) ? a_ovf : b_ovf) !== 1'b0) begin
                fails++;
                $display("[TB] FAIL rand%0d_count: beats %0d credits %0d, expected %0d and %0d",
                         inst, (inst == 0) ? obs_a.size() : obs_b.size(),
                         ((inst == 0) ? cred_a : cred_b) - c0,
                         (inst == 0) ? exp_a.size() : exp_b.size(), fq.size());
            end
            for (int i = 0; i < ((inst == 0) ? exp_a.size() : exp_b.size()); i++) begin
                beat_t o, e;
                if (i >= ((inst == 0) ? obs_a.size() : obs_b.size())) break;
                o = (inst == 0) ? obs_a[i] : obs_b[i];
                e = (inst == 0) ? exp_a[i] : exp_b[i];
                tests++;
                if (o.data !== e.data || o.last !== e.last || o.tdest !== e.tdest || o.tid !== e.tid) begin
                    fails++;
                    $display("[TB] FAIL rand%0d_beat%0d: got %h/%b/%0d/%0d, expected %h/%b/%0d/%0d",
                             inst, i, o.data, o.last, o.tdest, o.tid, e.data, e.last, e.tdest, e.tid);
                end
            end
        end
    endtask

    initial begin
        a_data = '0; a_dest = '0; a_tail = 1'b0; a_send = 1'b0; a_tready = 1'b1;
        b_data = '0; b_dest = '0; b_tail = 1'b0; b_send = 1'b0; b_tready = 1'b1;
        model_reset();
        test_reset();
        test_single();
        test_sf2_packet();
        test_early_tail();
        test_backpressure();
        test_overflow();
        test_reset_midpacket();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
